// File: rtl/debouncer_pkg.sv
// Shared constants and types for the debouncer slice.
package debouncer_pkg;

  // Depth of the input synchronizer chain.
  localparam int SYNC_STAGES = 2;

  // Largest counter width the debouncer accepts.
  localparam int WIDTH_MAX = 24;

  // Action the stability counter takes on a given cycle.
  typedef enum logic [1:0] {
    CNT_CLEAR = 2'd0,
    CNT_HOLD  = 2'd1,
    CNT_INC   = 2'd2,
    CNT_LOAD  = 2'd3
  } cnt_action_t;

endpackage

// File: rtl/debouncer_sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous level into the Clock domain.
module sync_2ff
  import debouncer_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw level through the chain every cycle; reset clears it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: Out follows the synchronized input only after it has been stable
// for 2^Width consecutive enabled cycles.
// Optional macro DEBOUNCER_EDGE_EN builds registered Rise/Fall pulses; without
// it both ports are tied to 0.
module debouncer
  import debouncer_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  input  logic In,
  output logic Out,
  output logic Rise,
  output logic Fall
);

  if (Width < 1 || Width > WIDTH_MAX) begin : g_width_check
    $error("debouncer: Width must be within 1..WIDTH_MAX");
  end

  logic             s2;
  logic [Width-1:0] cnt;
  logic [Width-1:0] cnt_next;
  logic             out_next;
  cnt_action_t      action;

  sync_2ff u_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     (In),
    .q     (s2)
  );

  // Decide what the counter does this cycle; the terminal count reloads Out
  // instead of wrapping.
  always_comb begin
    action   = CNT_CLEAR;
    cnt_next = '0;
    out_next = Out;
    if (s2 == Out) begin
      action = CNT_CLEAR;
    end else if (!Enable) begin
      action = CNT_HOLD;
    end else if (cnt == {Width{1'b1}}) begin
      action = CNT_LOAD;
    end else begin
      action = CNT_INC;
    end
    case (action)
      CNT_CLEAR: cnt_next = '0;
      CNT_HOLD:  cnt_next = cnt;
      CNT_INC:   cnt_next = cnt + 1'b1;
      CNT_LOAD: begin
        cnt_next = '0;
        out_next = s2;
      end
      default:   cnt_next = '0;
    endcase
  end

  // Register the counter and the debounced level.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
      Out <= 1'b0;
    end else begin
      cnt <= cnt_next;
      Out <= out_next;
    end
  end

`ifdef DEBOUNCER_EDGE_EN
  // Pulse Rise/Fall on the same cycle Out shows its new value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Rise <= 1'b0;
      Fall <= 1'b0;
    end else begin
      Rise <= (action == CNT_LOAD) && s2;
      Fall <= (action == CNT_LOAD) && !s2;
    end
  end
`else
  assign Rise = 1'b0;
  assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_debouncer.sv
// Testbench for debouncer (Width=3): directed latency scenarios plus random
// bouncing input, all checked against a run-length reference model.
module tb_debouncer;

  localparam int W = 3;
  localparam int STABLE_LEN = 1 << W;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Enable = 1'b0;
  logic In = 1'b0;
  logic Out, Rise, Fall;

  int assertCount = 0;
  int failCount = 0;

  // Reference model: a two-deep delay line, a run length of enabled
  // disagreeing cycles, and the expected outputs.
  logic syncQ[$];
  int   runLen;
  logic modelOut, modelRise, modelFall;

  debouncer #(.Width(W)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (Enable),
    .In     (In),
    .Out    (Out),
    .Rise   (Rise),
    .Fall   (Fall)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic modelStep(input logic rst, input logic en, input logic din);
    logic oldS2;
    logic prevOut;
    prevOut = modelOut;
    if (rst) begin
      syncQ = '{1'b0, 1'b0};
      runLen = 0;
      modelOut = 1'b0;
    end else begin
      oldS2 = syncQ[0];
      void'(syncQ.pop_front());
      syncQ.push_back(din);
      if (oldS2 == modelOut) begin
        runLen = 0;
      end else if (en) begin
        runLen++;
        if (runLen == STABLE_LEN) begin
          modelOut = oldS2;
          runLen = 0;
        end
      end
    end
`ifdef DEBOUNCER_EDGE_EN
    modelRise = !rst && !prevOut && modelOut;
    modelFall = !rst && prevOut && !modelOut;
`else
    modelRise = 1'b0;
    modelFall = 1'b0;
`endif
  endtask

  // Drive one cycle of inputs, clock it, and compare all outputs to the model.
  task automatic applyStimulus(input logic rst, input logic en, input logic din);
    Reset = rst;
    Enable = en;
    In = din;
    @(posedge Clock);
    modelStep(rst, en, din);
    #1;
    checkOutput("out", Out, modelOut);
    checkOutput("rise", Rise, modelRise);
    checkOutput("fall", Fall, modelFall);
  endtask

  // Hold inputs until Out reaches the target level; report edges taken.
  task automatic measureLatency(input string tag, input logic target, input int expected,
                                input bit toggleEnable);
    int edges;
    bit done;
    edges = 0;
    done = 1'b0;
    while (!done && edges < 60) begin
      edges++;
      applyStimulus(1'b0, toggleEnable ? logic'(edges % 2) : 1'b1, target);
      if (Out == target) done = 1'b1;
    end
    checkOutput(tag, edges, expected);
  endtask

  initial begin
    syncQ = '{1'b0, 1'b0};
    runLen = 0;
    modelOut = 1'b0;
    modelRise = 1'b0;
    modelFall = 1'b0;

    // Reset held two cycles with In high.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Clean rising edge.
    measureLatency("rise_latency", 1'b1, 10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);

    // Clean falling edge.
    measureLatency("fall_latency", 1'b0, 10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Bounce: 5 high, 3 low, then held high.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    measureLatency("bounce_latency", 1'b1, 10, 1'b0);

    // Enable toggling every cycle doubles the counting time.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    measureLatency("enable_toggle_latency", 1'b1, 17, 1'b1);

    // Reset mid-count discards progress.
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("out_after_mid_reset", Out, 0);
    measureLatency("post_reset_latency", 1'b1, 10, 1'b0);

    // Random bouncing input with random enable and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic din, en, rst;
      din = ($urandom_range(0, 19) == 0) ? ~In : In;
      en = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      applyStimulus(rst, en, din);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
